m_lsu: RTL and testbench

Memory-stage load/store unit for the 5-stage RISC-V core. It consumes the EX/M pipeline outputs: `MemRead_M`, `MemWrite_M`, `funct3_M`, `alu_result_M` (effective address) and `rs2_rdata_M` (store data). It issues the access to the data memory over a request/grant/read-valid handshake and returns the aligned, extended load result. While an access is outstanding, it stalls the pipeline.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_load_ext.sv | 27 ++
 rtl/m_lsu.sv | 156 +++++++++++++++
 tb/tb_m_lsu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type and byte-enable width.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_ext.sv
// Load alignment: picks the byte/halfword at the access offset out of the raw
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per M-stage
// instruction over req/gnt/rvalid and stalls the pipeline until it completes.
// Optional macro LSU_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of issuing them.
module m_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_M,
    input  logic              MemWrite_M,
    input  logic [2:0]        funct3_M,
    input  logic [ADDR_W-1:0] alu_result_M,
    input  logic [DATA_W-1:0] rs2_rdata_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] load_data_M,
    output logic              lsu_stall,
    output logic              lsu_misalign
);

    lsu_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [BE_W-1:0]   be_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [2:0]        f3_reg;
    logic [1:0]        off_reg;
    logic [DATA_W-1:0] load_reg;

    logic              access, trap, issue, capture;
    logic [1:0]        a, off_eff;
    logic [BE_W-1:0]   be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] ext_data;

    assign access = MemRead_M | MemWrite_M;
    assign a      = alu_result_M[1:0];

    // Halfword/word offsets are forced to natural alignment; with trapping enabled
    // misaligned accesses never reach this path, so the forcing is harmless there.
    always_comb begin
        off_eff    = a;
        be_next    = 4'b1111;
        wdata_next = rs2_rdata_M;
        case (funct3_M[1:0])
            2'b00: begin
                be_next    = 4'b0001 << a;
                wdata_next = {4{rs2_rdata_M[7:0]}};
            end
            2'b01: begin
                off_eff    = {a[1], 1'b0};
                be_next    = 4'b0011 << {a[1], 1'b0};
                wdata_next = {2{rs2_rdata_M[15:0]}};
            end
            default: off_eff = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = access &&
                  (((funct3_M[1:0] == 2'b01) && a[0]) ||
                   ((funct3_M[1:0] != 2'b00) && (funct3_M[1:0] != 2'b01) && (a != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    assign issue        = (state_reg == IDLE) && access && !trap;
    assign lsu_misalign = (state_reg == IDLE) && trap;

    always_comb begin
        state_next = state_reg;
        dmem_req   = 1'b0;
        lsu_stall  = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    lsu_stall  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                dmem_req  = 1'b1;
                lsu_stall = 1'b1;
                if (dmem_gnt) begin
                    if (we_reg) begin
                        state_next = DONE;
                    end else if (dmem_rvalid) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dmem_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    lsu_load_ext u_load_ext (
        .rdata  (dmem_rdata),
        .offset (off_reg),
        .funct3 (f3_reg),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            f3_reg    <= 3'b000;
            off_reg   <= 2'b00;
            load_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (issue) begin
                addr_reg  <= {alu_result_M[ADDR_W-1:2], 2'b00};
                be_reg    <= be_next;
                wdata_reg <= wdata_next;
                we_reg    <= MemWrite_M;
                f3_reg    <= funct3_M;
                off_reg   <= off_eff;
            end
            if (capture) begin
                load_reg <= ext_data;
            end
        end
    end

    assign dmem_we     = we_reg;
    assign dmem_addr   = addr_reg;
    assign dmem_be     = be_reg;
    assign dmem_wdata  = wdata_reg;
    assign load_data_M = load_reg;

endmodule

// File: tb/tb_m_lsu.sv
// Directed bench for m_lsu: a table of load/store transactions with a simple
// memory responder, plus hand sequences for reset, spurious handshakes and misalignment.
module tb_m_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] alu_result_M, rs2_rdata_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_M;
    logic        lsu_stall, lsu_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemRead_M    (MemRead_M),
        .MemWrite_M   (MemWrite_M),
        .funct3_M     (funct3_M),
        .alu_result_M (alu_result_M),
        .rs2_rdata_M  (rs2_rdata_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .load_data_M  (load_data_M),
        .lsu_stall    (lsu_stall),
        .lsu_misalign (lsu_misalign)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gw, input int rw,
                                input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic [31:0] eld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_wait = gw; v.rv_wait = rw; v.exp_addr = ea; v.exp_be = ebe;
        v.exp_wdata = ewd; v.exp_load = eld;
        return v;
    endfunction

    // Drives one M-stage instruction, acts as the memory, and checks the request
    // fields on every REQ cycle plus latency, stall count and load result in DONE.
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc = 0, stalls = 0, reqs = 0, waits = 0, exp_cyc;
        bit  done = 0, gnt_given = 0;
        bit  is_load;
        is_load = v.rd && !v.wr;
        exp_cyc = 3 + v.gnt_wait + (is_load ? v.rv_wait : 0);
        MemRead_M = v.rd; MemWrite_M = v.wr; funct3_M = v.f3;
        alu_result_M = v.addr; rs2_rdata_M = v.wdata;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            dmem_rdata = v.rdata;
            if (lsu_stall) stalls++;
            else done = 1;
            if (dmem_req) begin
                reqs++;
                check($sformatf("v%0d addr", idx), dmem_addr, v.exp_addr);
                check($sformatf("v%0d be", idx), {28'd0, dmem_be}, {28'd0, v.exp_be});
                check($sformatf("v%0d we", idx), {31'd0, dmem_we}, {31'd0, v.wr});
                if (v.wr) check($sformatf("v%0d wdata", idx), dmem_wdata, v.exp_wdata);
                if (reqs == v.gnt_wait + 1) begin
                    dmem_gnt  = 1'b1;
                    gnt_given = 1;
                    if (is_load && v.rv_wait == 0) dmem_rvalid = 1'b1;
                end
            end else if (gnt_given && is_load && lsu_stall) begin
                waits++;
                if (waits == v.rv_wait) dmem_rvalid = 1'b1;
            end
            if (done) begin
                check($sformatf("v%0d load_data", idx), load_data_M, v.exp_load);
                check($sformatf("v%0d misalign", idx), {31'd0, lsu_misalign}, 32'd0);
            end
            @(posedge clk);
            #1;
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
        end
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL v%0d timeout: no DONE within %0d cycles", idx, cyc);
        end else begin
            check($sformatf("v%0d cycles", idx), cyc, exp_cyc);
            check($sformatf("v%0d stalls", idx), stalls, exp_cyc - 1);
            check($sformatf("v%0d reqs", idx), reqs, v.gnt_wait + 1);
        end
        $display("vec %0d rd=%0b wr=%0b f3=%0d addr=%h cycles=%0d stalls=%0d load=%h",
                 idx, v.rd, v.wr, v.f3, v.addr, cyc, stalls, load_data_M);
    endtask

    initial begin
        rst_n = 1'b0;
        MemRead_M = 0; MemWrite_M = 0; funct3_M = 3'b000;
        alu_result_M = '0; rs2_rdata_M = '0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;

        //             rd wr f3      addr        wdata         rdata        gw rw exp_addr    be       exp_wdata     exp_load
        vecs.push_back(mk(0, 1, 3'b000, 32'h103, 32'h0000_00AB, 32'h0,        0, 0, 32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h202, 32'h0,         32'h12F4_5678, 0, 1, 32'h200, 4'b0100, 32'h0, 32'hFFFF_FFF4));
        vecs.push_back(mk(1, 0, 3'b100, 32'h202, 32'h0,         32'h12F4_5678, 0, 1, 32'h200, 4'b0100, 32'h0, 32'h0000_00F4));
        vecs.push_back(mk(1, 0, 3'b101, 32'h002, 32'h0,         32'h8765_4321, 3, 0, 32'h000, 4'b1100, 32'h0, 32'h0000_8765));
        vecs.push_back(mk(1, 0, 3'b010, 32'h300, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'h300, 4'b1111, 32'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 1, 3'b010, 32'h304, 32'h1122_3344, 32'h0,         0, 0, 32'h304, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 0, 3'b001, 32'h012, 32'h0,         32'h8001_7FFF, 1, 2, 32'h010, 4'b1100, 32'h0, 32'hFFFF_8001));
        vecs.push_back(mk(1, 0, 3'b001, 32'h010, 32'h0,         32'h8001_7FFF, 0, 0, 32'h010, 4'b0011, 32'h0, 32'h0000_7FFF));
        vecs.push_back(mk(0, 1, 3'b001, 32'h022, 32'hCAFE_5A5A, 32'h0,         2, 0, 32'h020, 4'b1100, 32'h5A5A_5A5A, 32'h0000_7FFF));
        vecs.push_back(mk(1, 0, 3'b000, 32'h041, 32'h0,         32'h0000_8000, 0, 0, 32'h040, 4'b0010, 32'h0, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 0, 3'b100, 32'h043, 32'h0,         32'h7F00_0000, 1, 1, 32'h040, 4'b1000, 32'h0, 32'h0000_007F));
        vecs.push_back(mk(1, 1, 3'b000, 32'h050, 32'h0000_0012, 32'hFFFF_FFFF, 0, 0, 32'h050, 4'b0001, 32'h1212_1212, 32'h0000_007F));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req", {31'd0, dmem_req}, 32'd0);
        check("rst stall", {31'd0, lsu_stall}, 32'd0);
        check("rst load", load_data_M, 32'd0);
        check("rst addr", dmem_addr, 32'd0);
        check("rst be", {28'd0, dmem_be}, 32'd0);
        check("rst wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned LW is flagged for one cycle, never requested, never stalls
        MemRead_M = 1; funct3_M = 3'b010; alu_result_M = 32'h006;
        @(negedge clk);
        check("trap misalign", {31'd0, lsu_misalign}, 32'd1);
        check("trap stall", {31'd0, lsu_stall}, 32'd0);
        check("trap req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk);
        #1;
        MemRead_M = 0;
        @(negedge clk);
        check("trap req after", {31'd0, dmem_req}, 32'd0);
        check("trap misalign after", {31'd0, lsu_misalign}, 32'd0);
        check("trap load kept", load_data_M, 32'h0000_007F);
        $display("trap seq LW 0x006 misalign=%0b", lsu_misalign);
        @(posedge clk);
        #1;
`else
        run_vec(mk(1, 0, 3'b010, 32'h006, 32'h0, 32'h0102_0304, 0, 0, 32'h004, 4'b1111, 32'h0, 32'h0102_0304), 100);
`endif

        // Spurious gnt/rvalid while idle must be ignored
        dmem_rvalid = 1; dmem_gnt = 1; dmem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        check("spur req", {31'd0, dmem_req}, 32'd0);
        check("spur stall", {31'd0, lsu_stall}, 32'd0);
        @(posedge clk);
        #1;
        dmem_rvalid = 0; dmem_gnt = 0;
        @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
        check("spur load kept", load_data_M, 32'h0000_007F);
`else
        check("spur load kept", load_data_M, 32'h0102_0304);
`endif
        check("spur req after", {31'd0, dmem_req}, 32'd0);
        $display("spurious rvalid/gnt in IDLE load=%h", load_data_M);

        // Reset while a load waits for gnt, with rvalid pending
        @(posedge clk);
        #1;
        MemRead_M = 1; funct3_M = 3'b010; alu_result_M = 32'h300;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid req before rst", {31'd0, dmem_req}, 32'd1);
        MemRead_M = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hAAAA_AAAA;
        rst_n = 1'b0;
        #1;
        check("mid rst req", {31'd0, dmem_req}, 32'd0);
        check("mid rst stall", {31'd0, lsu_stall}, 32'd0);
        check("mid rst addr", dmem_addr, 32'd0);
        check("mid rst be", {28'd0, dmem_be}, 32'd0);
        check("mid rst we", {31'd0, dmem_we}, 32'd0);
        check("mid rst load", load_data_M, 32'd0);
        @(posedge clk);
        #1;
        check("mid rst load held", load_data_M, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid = 0;
        @(negedge clk);
        check("post rst req", {31'd0, dmem_req}, 32'd0);
        check("post rst stall", {31'd0, lsu_stall}, 32'd0);
        check("post rst load", load_data_M, 32'd0);
        $display("reset mid-access req=%0b load=%h", dmem_req, load_data_M);
        @(posedge clk);
        #1;
        run_vec(mk(1, 0, 3'b001, 32'h012, 32'h0, 32'h8001_7FFF, 0, 0, 32'h010, 4'b1100, 32'h0, 32'hFFFF_8001), 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
